// File: rtl/ising_observables_if.sv
// ising_observables_if
//   Row-stream / result handshake bundle for the Ising observable stage.
//   master : lattice controller side (drives rows, takes results)
//   slave  : ising_observables side
// Signals:
//   row_valid/row_ready/row_data : one lattice row per transfer (bit j = column j, 1 = +1)
//   out_valid/out_ready          : frame result handshake
//   energy (EW, signed), mag (MW, signed)
//   abs_mag (MW-1, unsigned)     : only when ISING_OBS_ABSMAG_EN is defined
interface ising_observables_if #(
  parameter int N  = 32,
  parameter int EW = $clog2(4*N*N)+2,
  parameter int MW = $clog2(N*N)+2
);
  logic                 row_valid;
  logic                 row_ready;
  logic [N-1:0]         row_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [EW-1:0] energy;
  logic signed [MW-1:0] mag;
`ifdef ISING_OBS_ABSMAG_EN
  logic [MW-2:0]        abs_mag;
`endif

  modport master (
    output row_valid, row_data, out_ready,
    input  row_ready, out_valid, energy, mag
`ifdef ISING_OBS_ABSMAG_EN
    , input abs_mag
`endif
  );

  modport slave (
    input  row_valid, row_data, out_ready,
    output row_ready, out_valid, energy, mag
`ifdef ISING_OBS_ABSMAG_EN
    , output abs_mag
`endif
  );
endinterface

// File: rtl/ising_observables.sv
// ising_observables
//   Consumes one N x N spin lattice streamed row by row (rows 0..N-1, no
//   framing) and produces the periodic-boundary Ising energy
//   E = -sum_i s_i * (4 neighbours) and the magnetization sum per frame.
//   Optional macro ISING_OBS_ABSMAG_EN adds abs_mag = |mag|.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : ising_observables_if.slave (row stream in, result out)
// Frame flow: ACCEPT (N row transfers) -> WRAP (1 cycle, closes the row
//   0 / row N-1 bond ring and registers results) -> DONE (hold result
//   until taken) -> ACCEPT.

// Popcount of a W-bit vector; written as a flat sum, which synthesis
// balances into an adder tree.
module ising_popcnt #(
  parameter int W  = 32,
  parameter int CW = $clog2(W+1)
) (
  input  logic [W-1:0]  v_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + CW'(v_i[i]);
  end
endmodule

module ising_observables #(
  parameter int N  = 32,
  parameter int EW = $clog2(4*N*N)+2,
  parameter int MW = $clog2(N*N)+2
) (
  input  logic               clk,
  input  logic               reset,
  ising_observables_if.slave bus
);
  localparam int CW = $clog2(N+1);
  localparam int AW = $clog2(N*N)+2;  // holds +-N^2 per bond accumulator
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {ACCEPT, WRAP, DONE} state_e;

  state_e               state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N-1:0]         prev_q, prev_d;
  logic [N-1:0]         row0_q, row0_d;
  logic signed [AW-1:0] acc_h_q, acc_h_d;
  logic signed [AW-1:0] acc_v_q, acc_v_d;
  logic signed [MW-1:0] acc_m_q, acc_m_d;
  logic signed [EW-1:0] energy_q, energy_d;
  logic signed [MW-1:0] mag_q, mag_d;
`ifdef ISING_OBS_ABSMAG_EN
  logic [MW-2:0]        abs_q, abs_d;
  logic [MW-1:0]        abs_full;
`endif

  // Bond term for N pairs with pc mismatches: aligned pairs give +1,
  // anti-aligned -1, so sum = N - 2*pc.
  function automatic logic signed [AW-1:0] bond(input logic [CW-1:0] pc);
    return AW'(N) - AW'({pc, 1'b0});
  endfunction

  logic [N-1:0]  row;
  logic [CW-1:0] pc_h, pc_v, pc_w, pc_m;
  logic          xfer_in;
  logic signed [EW-1:0] tot;

  assign row = bus.row_data;

  // Horizontal neighbours via a 1-bit rotate closes the column ring.
  ising_popcnt #(.W(N), .CW(CW)) u_pc_h (.v_i(row ^ {row[N-2:0], row[N-1]}), .cnt_o(pc_h));
  ising_popcnt #(.W(N), .CW(CW)) u_pc_v (.v_i(row ^ prev_q),                  .cnt_o(pc_v));
  ising_popcnt #(.W(N), .CW(CW)) u_pc_w (.v_i(prev_q ^ row0_q),               .cnt_o(pc_w));
  ising_popcnt #(.W(N), .CW(CW)) u_pc_m (.v_i(row),                           .cnt_o(pc_m));

  // rdy_q gates acceptance so row_ready stays low during reset and the
  // first cycle after it, with no path from row_valid.
  assign xfer_in = bus.row_valid && rdy_q && (state_q == ACCEPT);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    prev_d   = prev_q;
    row0_d   = row0_q;
    acc_h_d  = acc_h_q;
    acc_v_d  = acc_v_q;
    acc_m_d  = acc_m_q;
    energy_d = energy_q;
    mag_d    = mag_q;
    tot      = '0;
`ifdef ISING_OBS_ABSMAG_EN
    abs_d    = abs_q;
    abs_full = acc_m_q[MW-1] ? MW'(-acc_m_q) : MW'(acc_m_q);
`endif
    case (state_q)
      ACCEPT: begin
        if (xfer_in) begin
          acc_h_d = acc_h_q + bond(pc_h);
          acc_m_d = acc_m_q + MW'({pc_m, 1'b0}) - MW'(N);
          if (idx_q != '0) acc_v_d = acc_v_q + bond(pc_v);
          else             row0_d  = row;
          prev_d = row;
          idx_d  = idx_q + 1'b1;
          if (idx_q == IW'(N-1)) state_d = WRAP;
        end
      end
      WRAP: begin
        // Each bond is seen once here; the Hamiltonian counts it twice.
        tot      = EW'(acc_h_q) + EW'(acc_v_q) + EW'(bond(pc_w));
        energy_d = -(tot + tot);
        mag_d    = acc_m_q;
`ifdef ISING_OBS_ABSMAG_EN
        abs_d    = abs_full[MW-2:0];
`endif
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          acc_h_d = '0;
          acc_v_d = '0;
          acc_m_d = '0;
          idx_d   = '0;
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
    rdy_d = (state_d == ACCEPT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ACCEPT;
      rdy_q    <= 1'b0;
      idx_q    <= '0;
      prev_q   <= '0;
      row0_q   <= '0;
      acc_h_q  <= '0;
      acc_v_q  <= '0;
      acc_m_q  <= '0;
      energy_q <= '0;
      mag_q    <= '0;
`ifdef ISING_OBS_ABSMAG_EN
      abs_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      idx_q    <= idx_d;
      prev_q   <= prev_d;
      row0_q   <= row0_d;
      acc_h_q  <= acc_h_d;
      acc_v_q  <= acc_v_d;
      acc_m_q  <= acc_m_d;
      energy_q <= energy_d;
      mag_q    <= mag_d;
`ifdef ISING_OBS_ABSMAG_EN
      abs_q    <= abs_d;
`endif
    end
  end

  assign bus.row_ready = rdy_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.energy    = energy_q;
  assign bus.mag       = mag_q;
`ifdef ISING_OBS_ABSMAG_EN
  assign bus.abs_mag   = abs_q;
`endif
endmodule

// File: tb/tb_ising_observables.sv
// tb_ising_observables
//   Directed frames with hand-computed energy/mag for N=32, including
//   backpressure, row_valid gaps and mid-frame reset.
module tb_ising_observables;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ising_observables_if #(.N(N)) bus ();
  ising_observables #(.N(N)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  logic [N-1:0] rows [N];

  always @(posedge clk) if (bus.out_valid && bus.out_ready) xfers++;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the row transfers.
  task automatic push_row(input logic [N-1:0] d);
    int n;
    bus.row_valid = 1'b1;
    bus.row_data  = d;
    n = 0;
    while (!bus.row_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("row_timeout", 0, 1);
    @(posedge clk); #1;
    bus.row_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit gaps, input int e_exp,
                           input int m_exp, input int hold);
    int x0, e0, m0;
    x0 = xfers;
    for (int r = 0; r < N; r++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      push_row(rows[r]);
    end
    // edge k just passed (last row): WRAP, result not yet visible
    chk({tag, "_vld_k"}, int'(bus.out_valid), 0);
    chk({tag, "_rdy_k"}, int'(bus.row_ready), 0);
    @(posedge clk); #1;
    chk({tag, "_vld_k1"}, int'(bus.out_valid), 1);
    chk({tag, "_energy"}, int'(bus.energy), e_exp);
    chk({tag, "_mag"}, int'(bus.mag), m_exp);
`ifdef ISING_OBS_ABSMAG_EN
    chk({tag, "_absmag"}, int'(bus.abs_mag), (m_exp < 0) ? -m_exp : m_exp);
`endif
    e0 = int'(bus.energy);
    m0 = int'(bus.mag);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, int'(bus.out_valid), 1);
      chk({tag, "_hold_rdy"}, int'(bus.row_ready), 0);
      chk({tag, "_hold_e"}, int'(bus.energy), e0);
      chk({tag, "_hold_m"}, int'(bus.mag), m0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_vld_after"}, int'(bus.out_valid), 0);
    chk({tag, "_rdy_after"}, int'(bus.row_ready), 1);
    chk({tag, "_xfers"}, xfers - x0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", int'(bus.row_ready), 0);
    chk("rst_vld", int'(bus.out_valid), 0);
    chk("rst_energy", int'(bus.energy), 0);
    chk("rst_mag", int'(bus.mag), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy", int'(bus.row_ready), 1);

    for (int r = 0; r < N; r++) rows[r] = '1;
    run_frame("ones", 1'b0, -4096, 1024, 0);

    for (int r = 0; r < N; r++) rows[r] = '0;
    run_frame("zeros_bp", 1'b0, -4096, -1024, 5);

    for (int r = 0; r < N; r++) rows[r] = (r % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
    run_frame("checker", 1'b0, 4096, 0, 0);

    for (int r = 0; r < N; r++) rows[r] = '1;
    rows[5][7] = 1'b0;
    run_frame("flip_r5b7", 1'b0, -4080, 1022, 0);

    for (int r = 0; r < N; r++) rows[r] = '1;
    rows[0][0] = 1'b0;
    run_frame("flip_r0b0", 1'b0, -4080, 1022, 0);

    for (int r = 0; r < N; r++) rows[r] = (r < 16) ? '1 : '0;
    run_frame("half_gaps", 1'b1, -3840, 0, 0);

    // mid-frame reset: last result (-3840) must be wiped
    for (int r = 0; r < 11; r++) push_row('1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_energy", int'(bus.energy), 0);
    chk("mid_rst_mag", int'(bus.mag), 0);
    chk("mid_rst_vld", int'(bus.out_valid), 0);
    chk("mid_rst_rdy", int'(bus.row_ready), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < N; r++) rows[r] = '1;
    run_frame("ones_after_rst", 1'b0, -4096, 1024, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ising_observables.md
# ising_observables

Downstream observable stage for the checkerboard Ising spin lattice. Consumes one full lattice snapshot streamed row by row after an update sweep and computes the total energy (Hamiltonian, periodic boundaries) and the raw magnetization sum. It offloads the per-frame energy/magnetization loops from the lattice controller and presents one result per frame over a valid/ready handshake.

## Interface

Parameters:
- `N`, default 32: lattice side length. Must be a power of two, 4..64.
- `EW`, default `$clog2(4*N*N)+2` (14 for N=32): energy output width, signed.
- `MW`, default `$clog2(N*N)+2` (12 for N=32): magnetization output width, signed.

Ports:
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `row_valid`, input, 1: `row_data` holds the next lattice row.
- `row_ready`, output, 1: the block accepts a row this cycle.
- `row_data`, input, N: one lattice row. Bit j is column j; 1 = spin +1, 0 = spin -1.
- `out_valid`, output, 1: `energy` and `mag` hold a completed frame result.
- `out_ready`, input, 1: the consumer takes the result.
- `energy`, output, EW, signed: E = -Σ_i s_i·(sum of its 4 neighbours). Each bond counts twice, so the range is ±4·N².
- `mag`, output, MW, signed: Σ s_i, range ±N².

## Operation

- Transfers: a row transfers on a rising edge with `row_valid && row_ready`. A result transfers on a rising edge with `out_valid && out_ready`.
- Row order: rows arrive in order 0..N-1. The internal `row_idx` counts 0..N-1. No framing signal is used.
- State `ACCEPT`:
  - Holds `row_ready`=1 and `out_valid`=0.
  - On each row transfer:
    - `acc_h += N - 2·popcount(row ^ rotl(row,1))` (circular horizontal bonds).
    - `acc_m += 2·popcount(row) - N`.
    - If `row_idx`>0: `acc_v += N - 2·popcount(row ^ prev)`.
    - If `row_idx`==0: store the row in `row0`.
    - Then `prev <= row` and `row_idx++`.
  - A transfer at `row_idx`==N-1 moves to `WRAP`.
- State `WRAP` (exactly 1 cycle):
  - Holds `row_ready`=0.
  - Adds the wrap bond term `N - 2·popcount(prev ^ row0)`.
  - Registers `energy <= -2·(acc_h+acc_v+wrap)` and `mag <= acc_m`.
  - Sets `out_valid`=1 and moves to `DONE`.
- State `DONE`:
  - Holds `row_ready`=0.
  - `out_valid`, `energy` and `mag` stay stable until the result transfers.
  - On transfer: clear `acc_*` and `row_idx`, and return to `ACCEPT`.
- Arithmetic: accumulators are signed. `acc_h` and `acc_v` are sized for ±N² each, so no overflow is possible for legal N. Popcounts are combinational adder trees.
- `row_valid` is ignored outside `ACCEPT`. Rows are never dropped or buffered beyond `prev`/`row0`.

## Timing

- Reset values (`reset`=0, applied asynchronously):
  - State `ACCEPT`, `row_idx`=0.
  - `row_ready`=0 while reset is asserted, then 1 from the first edge after release.
  - `out_valid`=0, `energy`=0, `mag`=0, all accumulators 0.
- Reset mid-frame or mid-`DONE`: the partial frame or pending result is discarded and the block returns to the reset state.
- Throughput: 1 row per cycle. Minimum frame period is N+2 cycles (N accepts, 1 `WRAP`, 1 `DONE` handshake).
- Latency: if row N-1 transfers at edge k, `out_valid` is 1 after edge k+1. If `out_ready` is already high, the result transfers at edge k+2 and `row_ready` is 1 after edge k+2.
- There is no combinational path from `out_ready` or `row_valid` to any output.
- Gaps: `row_valid` may deassert at any row boundary. The accumulators simply hold their values.

## Configuration

- Macro `ISING_OBS_ABSMAG_EN`.
- Defined: adds output `abs_mag` (MW-1 bits, unsigned) = |Σ s_i|.
  - Registered in `WRAP` together with `mag`, held through `DONE`.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan

- All rows `0xFFFFFFFF` (N=32) -> `energy`=-4096, `mag`=1024, `abs_mag`=1024. `out_valid` is high after the edge following the row-31 transfer.
- All rows `0x00000000` -> `energy`=-4096, `mag`=-1024, `abs_mag`=1024.
- Checkerboard (even rows `0x55555555`, odd rows `0xAAAAAAAA`) -> `energy`=+4096, `mag`=0.
- All ones except row 5 bit 7 = 0 -> `energy`=-4080, `mag`=1022.
  - Variant: flip row 0 bit 0 instead. Same expected values, which exercises both the row and column wrap.
- Rows 0-15 all ones, rows 16-31 all zeros, with random `row_valid` gaps -> `energy`=-3840, `mag`=0.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles after `out_valid` -> `row_ready`=0 and outputs stable throughout; the result transfers exactly once.
  - Assert `reset` after row 10 of a frame -> all outputs 0 immediately. The next full all-ones frame yields -4096 / 1024.
